alu_logic_result_stage: RTL and testbench

- Registered stage directly downstream of the combinational logic unit (AND/OR/XOR/NOT/CPR).
- Captures the unit's result word and compare flags, together with the issuing opcode, into a small FIFO.
- Presents captured entries to writeback over a valid/ready handshake.
- Maintains an architectural compare-flag status register that changes only on CPR operations.

---
 rtl/alu_logic_result_stage_pkg.sv | 45 ++++
 rtl/alu_logic_result_stage_fifo.sv | 112 +++++++++++
 rtl/alu_logic_result_stage.sv | 111 +++++++++++
 tb/tb_alu_logic_result_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_logic_result_stage_pkg.sv
// -----------------------------------------------------------------------------
// CPU_package
// Shared CPU definitions used by the logic-unit result stage.
//   DATA_WIDTH          : datapath word width
//   enum_alu_opcode_t   : ALU opcode encoding (ALU_OP_AND is the all-zero code)
//   alu_result_entry_t  : one captured logic-unit result {opcode, data, flags}
//   CMP_EQ/CMP_GT/CMP_LT: one-hot compare flag encodings
//   is_logic_op()       : true for opcodes handled by the logic unit
// -----------------------------------------------------------------------------
package CPU_package;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    ALU_OP_AND = 4'd0,
    ALU_OP_OR  = 4'd1,
    ALU_OP_XOR = 4'd2,
    ALU_OP_NOT = 4'd3,
    ALU_OP_CPR = 4'd4,
    ALU_OP_ADD = 4'd5,
    ALU_OP_SUB = 4'd6,
    ALU_OP_SHL = 4'd7,
    ALU_OP_SHR = 4'd8
  } enum_alu_opcode_t;

  localparam logic [2:0] CMP_EQ = 3'b100;
  localparam logic [2:0] CMP_GT = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  typedef struct packed {
    enum_alu_opcode_t        opcode;
    logic [DATA_WIDTH-1:0]   data;
    logic [2:0]              flags;
  } alu_result_entry_t;

  function automatic logic is_logic_op(input enum_alu_opcode_t op);
    logic r;
    case (op)
      ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR, ALU_OP_NOT, ALU_OP_CPR: r = 1'b1;
      default:                                                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_logic_result_stage_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
// DEPTH-entry synchronous FIFO of alu_result_entry_t with a registered head.
// The head register always holds the entry at the read pointer while not empty,
// and keeps the last popped entry once the FIFO drains.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write i_entry (ignored when full)
//   i_entry   : entry to write
//   i_pop     : drop head entry (ignored when empty)
//   o_full    : occupancy == DEPTH
//   o_empty   : occupancy == 0
//   o_head    : registered head entry
// -----------------------------------------------------------------------------
import CPU_package::*;

module alu_result_fifo #(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  alu_result_entry_t i_entry,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output alu_result_entry_t o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  alu_result_entry_t r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  alu_result_entry_t r_head;

  logic              w_push;
  logic              w_pop;
  logic [PW-1:0]     w_rd_next;
  logic [CW-1:0]     w_count_next;
  alu_result_entry_t w_head_next;

  assign o_full  = (r_count == CNT_DEPTH);
  assign o_empty = (r_count == CNT_ZERO);
  assign o_head  = r_head;

  // Qualified push/pop, next pointers and occupancy
  always_comb begin
    w_push       = i_push && !o_full;
    w_pop        = i_pop && !o_empty;
    w_rd_next    = r_rd_ptr;
    w_count_next = r_count;
    if (w_pop) begin
      w_rd_next = r_rd_ptr + PTR_ONE;
    end else begin
      w_rd_next = r_rd_ptr;
    end
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Next head: the incoming entry becomes head when nothing older remains
  // after this edge's pop; otherwise read the slot at the new read pointer.
  always_comb begin
    w_head_next = r_head;
    if (w_count_next == CNT_ZERO) begin
      w_head_next = r_head;
    end else if ((r_count == CNT_ZERO) || ((r_count == CNT_ONE) && w_pop)) begin
      w_head_next = i_entry;
    end else begin
      w_head_next = r_mem[w_rd_next];
    end
  end

  // Pointer, occupancy and head registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= CNT_ZERO;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_head   <= w_head_next;
    end
  end

  // Entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

endmodule

// File: rtl/alu_logic_result_stage.sv
// -----------------------------------------------------------------------------
// alu_logic_result_stage
// Registered stage behind the combinational logic unit. Logic-unit results are
// queued in a DEPTH-entry FIFO and offered to writeback over valid/ready.
// Non-logic opcodes are accepted and dropped. cmp_flags latches the compare
// flags whenever a CPR is pushed.
// Optional macro ALU_RESULT_STATS_EN adds parameter CNT_WIDTH and the
// saturating pushed-op counter output op_count.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready            : input handshake (in_ready = !full)
//   in_opcode, logic_out,
//   logic_out_flag               : logic-unit opcode, result and compare flags
//   out_valid/out_ready          : output handshake
//   out_opcode/out_data/out_flag : head entry (registered)
//   cmp_flags                    : compare status register
//   op_count                     : pushed logic-op count (stats build only)
// -----------------------------------------------------------------------------
import CPU_package::*;

module alu_logic_result_stage #(
  parameter int DEPTH = 2
`ifdef ALU_RESULT_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  enum_alu_opcode_t      in_opcode,
  input  logic [DATA_WIDTH-1:0] logic_out,
  input  logic [2:0]            logic_out_flag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output enum_alu_opcode_t      out_opcode,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            out_flag,
  output logic [2:0]            cmp_flags
`ifdef ALU_RESULT_STATS_EN
  , output logic [CNT_WIDTH-1:0] op_count
`endif
);

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  alu_result_entry_t w_entry;
  alu_result_entry_t w_head;
  logic [2:0]        r_cmp_flags;

  assign in_ready   = !w_full;
  assign out_valid  = !w_empty;
  assign out_opcode = w_head.opcode;
  assign out_data   = w_head.data;
  assign out_flag   = w_head.flags;
  assign cmp_flags  = r_cmp_flags;

  // Push filter and entry formatting; CPR carries flags only, others data only
  always_comb begin
    w_push  = in_valid && !w_full && is_logic_op(in_opcode);
    w_pop   = !w_empty && out_ready;
    w_entry = '0;
    w_entry.opcode = in_opcode;
    if (in_opcode == ALU_OP_CPR) begin
      w_entry.data  = '0;
      w_entry.flags = logic_out_flag;
    end else begin
      w_entry.data  = logic_out;
      w_entry.flags = 3'b000;
    end
  end

  alu_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Compare status: loads at CPR push time, not when the entry is consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmp_flags <= 3'b000;
    end else if (w_push && (in_opcode == ALU_OP_CPR)) begin
      r_cmp_flags <= logic_out_flag;
    end
  end

`ifdef ALU_RESULT_STATS_EN
  logic [CNT_WIDTH-1:0] r_op_count;
  assign op_count = r_op_count;

  // Saturating count of pushed logic ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_push && (r_op_count != {CNT_WIDTH{1'b1}})) begin
      r_op_count <= r_op_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_alu_logic_result_stage.sv
import CPU_package::*;

module tb_alu_logic_result_stage;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  enum_alu_opcode_t      in_opcode;
  logic [DATA_WIDTH-1:0] logic_out;
  logic [2:0]            logic_out_flag;
  logic                  out_valid;
  logic                  out_ready;
  enum_alu_opcode_t      out_opcode;
  logic [DATA_WIDTH-1:0] out_data;
  logic [2:0]            out_flag;
  logic [2:0]            cmp_flags;
`ifdef ALU_RESULT_STATS_EN
  logic [1:0]            op_count;
`endif

  int n_tests;
  int n_fail;

`ifdef ALU_RESULT_STATS_EN
  alu_logic_result_stage #(.DEPTH(2), .CNT_WIDTH(2)) dut (
`else
  alu_logic_result_stage #(.DEPTH(2)) dut (
`endif
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_opcode      (in_opcode),
    .logic_out      (logic_out),
    .logic_out_flag (logic_out_flag),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_opcode     (out_opcode),
    .out_data       (out_data),
    .out_flag       (out_flag),
    .cmp_flags      (cmp_flags)
`ifdef ALU_RESULT_STATS_EN
    , .op_count     (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, sample point 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input enum_alu_opcode_t op,
                       input logic [7:0] d, input logic [2:0] f);
    in_valid       = v;
    in_opcode      = op;
    logic_out      = d;
    logic_out_flag = f;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, ALU_OP_AND, 8'h00, 3'b000);
    out_ready = 1'b0;
    step();
    step();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cmp_flags !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctl: out_valid=%b in_ready=%b cmp=%b, want 0 1 000", out_valid, in_ready, cmp_flags);
    end
    n_tests++;
    if (out_data !== 8'h00 || out_flag !== 3'b000 || out_opcode !== ALU_OP_AND) begin
      n_fail++;
      $display("FAIL reset_data: data=%h flag=%b op=%0d, want 00 000 0", out_data, out_flag, out_opcode);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_push();
    drive(1'b1, ALU_OP_AND, 8'h3C, 3'b000);
    step();
    drive(1'b0, ALU_OP_AND, 8'h00, 3'b000);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || out_flag !== 3'b000 || out_opcode !== ALU_OP_AND) begin
      n_fail++;
      $display("FAIL and_push: valid=%b data=%h flag=%b op=%0d, want 1 3c 000 0", out_valid, out_data, out_flag, out_opcode);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL empty_hold: valid=%b data=%h, want 0 3c", out_valid, out_data);
    end
  endtask

  task automatic test_full();
    drive(1'b1, ALU_OP_XOR, 8'hFF, 3'b000);
    step();
    drive(1'b1, ALU_OP_NOT, 8'h0F, 3'b000);
    step();
    n_tests++;
    if (in_ready !== 1'b0 || out_data !== 8'hFF || out_opcode !== ALU_OP_XOR) begin
      n_fail++;
      $display("FAIL full_ready: in_ready=%b data=%h, want 0 ff", in_ready, out_data);
    end
    drive(1'b1, ALU_OP_XOR, 8'h11, 3'b000);
    step();
    drive(1'b0, ALU_OP_AND, 8'h00, 3'b000);
    out_ready = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h0F || out_opcode !== ALU_OP_NOT || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pop_first: valid=%b data=%h op=%0d rdy=%b, want 1 0f 3 1", out_valid, out_data, out_opcode, in_ready);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h0F) begin
      n_fail++;
      $display("FAIL pop_second: valid=%b data=%h, want 0 0f (11 must be dropped)", out_valid, out_data);
    end
    // full + pop + valid input: pop happens, push refused this edge
    out_ready = 1'b0;
    drive(1'b1, ALU_OP_AND, 8'hA1, 3'b000);
    step();
    drive(1'b1, ALU_OP_AND, 8'hA2, 3'b000);
    step();
    drive(1'b1, ALU_OP_AND, 8'h22, 3'b000);
    out_ready = 1'b1;
    step();
    drive(1'b0, ALU_OP_AND, 8'h00, 3'b000);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'hA2 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_push: valid=%b data=%h rdy=%b, want 1 a2 1", out_valid, out_data, in_ready);
    end
    step();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'hA2) begin
      n_fail++;
      $display("FAIL full_no_push: valid=%b data=%h, want 0 a2", out_valid, out_data);
    end
  endtask

  task automatic test_cpr();
    drive(1'b1, ALU_OP_CPR, 8'h77, 3'b010);
    step();
    n_tests++;
    if (cmp_flags !== 3'b010 || out_flag !== 3'b010 || out_data !== 8'h00 || out_opcode !== ALU_OP_CPR) begin
      n_fail++;
      $display("FAIL cpr_push: cmp=%b flag=%b data=%h op=%0d, want 010 010 00 4", cmp_flags, out_flag, out_data, out_opcode);
    end
    drive(1'b1, ALU_OP_OR, 8'hA5, 3'b001);
    step();
    drive(1'b0, ALU_OP_AND, 8'h00, 3'b000);
    n_tests++;
    if (cmp_flags !== 3'b010) begin
      n_fail++;
      $display("FAIL cpr_hold: cmp=%b, want 010", cmp_flags);
    end
    out_ready = 1'b1;
    step();
    n_tests++;
    if (out_data !== 8'hA5 || out_flag !== 3'b000 || out_opcode !== ALU_OP_OR) begin
      n_fail++;
      $display("FAIL or_after_cpr: data=%h flag=%b op=%0d, want a5 000 1", out_data, out_flag, out_opcode);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    drive(1'b1, ALU_OP_AND, 8'h10, 3'b000);
    step();
    for (int i = 0; i < 10; i++) begin
      d = 8'h20 + 8'(i);
      drive(1'b1, ALU_OP_OR, d, 3'b000);
      out_ready = 1'b1;
      step();
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== d) begin
        n_fail++;
        $display("FAIL b2b_%0d: valid=%b rdy=%b data=%h, want 1 1 %h", i, out_valid, in_ready, out_data, d);
      end
    end
    drive(1'b0, ALU_OP_AND, 8'h00, 3'b000);
    step();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h29) begin
      n_fail++;
      $display("FAIL b2b_drain: valid=%b data=%h, want 0 29", out_valid, out_data);
    end
  endtask

  task automatic test_discard_and_reset();
    drive(1'b1, ALU_OP_ADD, 8'h55, 3'b100);
    step();
    drive(1'b0, ALU_OP_AND, 8'h00, 3'b000);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || cmp_flags !== 3'b010) begin
      n_fail++;
      $display("FAIL discard: rdy=%b valid=%b cmp=%b, want 1 0 010", in_ready, out_valid, cmp_flags);
    end
    drive(1'b1, ALU_OP_CPR, 8'h00, 3'b100);
    step();
    drive(1'b1, ALU_OP_AND, 8'h02, 3'b000);
    step();
    drive(1'b0, ALU_OP_AND, 8'h00, 3'b000);
    n_tests++;
    if (in_ready !== 1'b0 || cmp_flags !== 3'b100) begin
      n_fail++;
      $display("FAIL pre_rst_full: rdy=%b cmp=%b, want 0 100", in_ready, cmp_flags);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || cmp_flags !== 3'b000 || in_ready !== 1'b1 || out_data !== 8'h00 || out_flag !== 3'b000) begin
      n_fail++;
      $display("FAIL async_rst: valid=%b cmp=%b rdy=%b data=%h flag=%b, want 0 000 1 00 000", out_valid, cmp_flags, in_ready, out_data, out_flag);
    end
    step();
    rst = 1'b0;
    step();
  endtask

`ifdef ALU_RESULT_STATS_EN
  task automatic test_stats();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    n_tests++;
    if (op_count !== 2'd0) begin
      n_fail++;
      $display("FAIL stats_reset: op_count=%0d, want 0", op_count);
    end
    drive(1'b1, ALU_OP_ADD, 8'h01, 3'b000);
    step();
    n_tests++;
    if (op_count !== 2'd0) begin
      n_fail++;
      $display("FAIL stats_discard: op_count=%0d, want 0", op_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ALU_OP_XOR, 8'(i), 3'b000);
      step();
      n_tests++;
      if (op_count !== exp_cnt[i]) begin
        n_fail++;
        $display("FAIL stats_%0d: op_count=%0d, want %0d", i, op_count, exp_cnt[i]);
      end
    end
    drive(1'b0, ALU_OP_AND, 8'h00, 3'b000);
    step();
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single_push();
    test_full();
    test_cpr();
    test_back_to_back();
    test_discard_and_reset();
`ifdef ALU_RESULT_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
